if_fetch_stage: RTL and testbench

// - Instruction-fetch stage: owns the program counter and drives the combinational instruction ROM address.
// - Captures the returned word into the IF/ID pipeline register and presents it to decode with a valid/ready handshake.
// - Accepts PC redirects (jump/branch) from later stages; flushes the wrong-path word.

---
 rtl/if_fetch_stage_if.sv | 29 ++
 rtl/if_fetch_stage.sv | 104 ++++++++++
 tb/tb_if_fetch_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Interface bundling the fetch-stage bus: instruction ROM port, redirect port,
// IF/ID handshake towards decode and the delivered-word counter.
// master = fetch stage, slave = its environment (ROM, later stages, decode).
interface if_fetch_stage_if;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_pc_plus4;
    logic        if_pred_taken;
    logic [15:0] fetch_count;

    modport master (
        input  fetch_en, imem_inst, redirect_valid, redirect_pc, id_ready,
        output imem_addr, if_valid, if_pc, if_inst, if_pc_plus4, if_pred_taken,
               fetch_count
    );

    modport slave (
        output fetch_en, imem_inst, redirect_valid, redirect_pc, id_ready,
        input  imem_addr, if_valid, if_pc, if_inst, if_pc_plus4, if_pred_taken,
               fetch_count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM,
// registers the returned word into IF/ID and hands it to decode with
// valid/ready. Redirects from later stages flush the wrong-path word.
// Optional feature macro: IF_JUMP_PREDECODE_EN (jump predecode in fetch).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_stage_if.master  bus
);
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4;
    logic        advance;
`ifdef IF_JUMP_PREDECODE_EN
    logic        if_pred_taken_q, if_pred_taken_d;
`endif

    // Next-state: redirect beats advance beats hold.
    always_comb begin
        pc_plus4      = pc_q + PC_STEP;
        advance       = bus.fetch_en & (~if_valid_q | bus.id_ready);
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        if_pc_plus4_d = if_pc_plus4_q;
        fetch_count_d = fetch_count_q;
`ifdef IF_JUMP_PREDECODE_EN
        if_pred_taken_d = if_pred_taken_q;
`endif
        if (bus.redirect_valid) begin
            // Word fetched this cycle is on the wrong path: drop it.
            pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
            if_valid_d = 1'b0;
        end else if (advance) begin
            if_inst_d     = bus.imem_inst;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_plus4;
            if_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 16'd1;
            pc_d          = pc_plus4;
`ifdef IF_JUMP_PREDECODE_EN
            // Absolute jump: steer fetch now, decode sees pred_taken and must not redirect again.
            if (bus.imem_inst[31:26] == 6'b010010) begin
                pc_d            = {pc_plus4[31:28], bus.imem_inst[25:0], 2'b00};
                if_pred_taken_d = 1'b1;
            end else begin
                if_pred_taken_d = 1'b0;
            end
`endif
        end else if (!bus.fetch_en && bus.id_ready) begin
            // Decode consumed the word and fetch is paused: nothing to refill with.
            if_valid_d = 1'b0;
        end
    end

    // PC and IF/ID register; async reset discards any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_inst_q     <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            fetch_count_q <= 16'h0;
        end else begin
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef IF_JUMP_PREDECODE_EN
    // Predecode flag travels with the word in IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pred_taken_q <= 1'b0;
        end else begin
            if_pred_taken_q <= if_pred_taken_d;
        end
    end

    assign bus.if_pred_taken = if_pred_taken_q;
`else
    assign bus.if_pred_taken = 1'b0;
`endif

    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_inst     = if_inst_q;
    assign bus.if_pc_plus4 = if_pc_plus4_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stimulus, a spec-level model of the
// PC / IF-ID contents compared every cycle, plus literal spot checks.
module tb_if_fetch_stage;
    logic clk;
    logic rst_n;
    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 0;

    // ROM aliases every 256 bytes; word at 0x40 is a jump to byte 4.
    logic [31:0] rom [64];
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
        rom[16] = 32'h4800_0001;
    end
    assign bus.imem_inst = rom[bus.imem_addr[7:2]];

    // Model state: what fetch should hold after each edge.
    logic [31:0] m_pc, m_ipc, m_inst, m_pp4;
    logic        m_valid, m_pred;
    logic [15:0] m_cnt;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 0; m_ipc = 0; m_inst = 0; m_pp4 = 0; m_pred = 0; m_cnt = 0;
    endtask

    // One clock: apply inputs, predict, commit prediction after the edge.
    task automatic cyc(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
        logic [31:0] word, n_pc, n_ipc, n_inst, n_pp4;
        logic        n_valid, n_pred;
        logic [15:0] n_cnt;
        bus.fetch_en = fe; bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.id_ready = rdy;
        word = rom[m_pc[7:2]];
        n_pc = m_pc; n_valid = m_valid; n_ipc = m_ipc; n_inst = m_inst;
        n_pp4 = m_pp4; n_pred = m_pred; n_cnt = m_cnt;
        if (rv) begin
            n_pc = {rpc[31:2], 2'b00};
            n_valid = 0;
        end else if (fe && (!m_valid || rdy)) begin
            n_inst = word; n_ipc = m_pc; n_pp4 = m_pc + 4; n_valid = 1;
            n_cnt = m_cnt + 16'd1;
            n_pc = m_pc + 4;
`ifdef IF_JUMP_PREDECODE_EN
            n_pred = (word[31:26] == 6'b010010);
            if (n_pred) n_pc = {n_pc[31:28], word[25:0], 2'b00};
`endif
        end else if (!fe && rdy) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_valid = n_valid; m_ipc = n_ipc; m_inst = n_inst;
        m_pp4 = n_pp4; m_pred = n_pred; m_cnt = n_cnt;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("imem_addr", bus.imem_addr, m_pc);
            check("if_valid", {31'b0, bus.if_valid}, {31'b0, m_valid});
            check("fetch_count", {16'b0, bus.fetch_count}, {16'b0, m_cnt});
            check("if_pred_taken", {31'b0, bus.if_pred_taken}, {31'b0, m_pred});
            if (m_valid || !rst_n) begin
                check("if_pc", bus.if_pc, m_ipc);
                check("if_inst", bus.if_inst, m_inst);
                check("if_pc_plus4", bus.if_pc_plus4, m_pp4);
            end
        end
    end

    logic [15:0] rdy_pat;
    logic [15:0] fe_pat;

    initial begin
        rst_n = 0;
        bus.fetch_en = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.id_ready = 0;
        model_reset();
        cmp_on = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_count", {16'b0, bus.fetch_count}, 32'd0);
        rst_n = 1;

        // Streaming from reset
        cyc(1, 0, 0, 1);
        check("s1_if_pc", bus.if_pc, 32'h0);
        check("s1_addr", bus.imem_addr, 32'h4);
        cyc(1, 0, 0, 1);
        check("s2_if_pc", bus.if_pc, 32'h4);
        cyc(1, 0, 0, 1);
        check("s3_if_pc", bus.if_pc, 32'h8);
        check("s3_count", {16'b0, bus.fetch_count}, 32'd3);

        // Decode stall for 3 cycles
        repeat (3) cyc(1, 0, 0, 0);
        check("stall_if_pc", bus.if_pc, 32'h8);
        check("stall_addr", bus.imem_addr, 32'hC);
        check("stall_inst", bus.if_inst, 32'h1000_0002);
        cyc(1, 0, 0, 1);
        check("release_if_pc", bus.if_pc, 32'hC);

        // Redirect with misaligned target, then the jump word at 0x40
        cyc(1, 1, 32'h0000_0043, 1);
        check("redir_addr", bus.imem_addr, 32'h40);
        check("redir_valid", {31'b0, bus.if_valid}, 32'd0);
        cyc(1, 0, 0, 1);
        check("jump_if_pc", bus.if_pc, 32'h40);
`ifdef IF_JUMP_PREDECODE_EN
        check("jump_addr", bus.imem_addr, 32'h4);
        check("jump_pred", {31'b0, bus.if_pred_taken}, 32'd1);
`else
        check("jump_addr", bus.imem_addr, 32'h44);
        check("jump_pred", {31'b0, bus.if_pred_taken}, 32'd0);
`endif

        // Redirect during stall, and redirect with fetch disabled
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 32'h0000_0102, 0);
        check("rs_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rs_addr", bus.imem_addr, 32'h100);
        cyc(0, 1, 32'h0000_0200, 0);
        check("rfe_addr", bus.imem_addr, 32'h200);

        // fetch_en low with decode ready drains the register
        cyc(1, 0, 0, 1);
        check("fe_if_pc", bus.if_pc, 32'h200);
        cyc(0, 0, 0, 1);
        check("fe_drain_valid", {31'b0, bus.if_valid}, 32'd0);
        check("fe_drain_addr", bus.imem_addr, 32'h204);
        cyc(0, 0, 0, 0);

        // Async reset mid-stream at pc 0x2C
        cyc(1, 1, 32'h20, 1);
        repeat (3) cyc(1, 0, 0, 1);
        check("pre_rst_addr", bus.imem_addr, 32'h2C);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("arst_addr", bus.imem_addr, 32'h0);
        check("arst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("arst_if_pc", bus.if_pc, 32'h0);
        check("arst_inst", bus.if_inst, 32'h0);
        check("arst_count", {16'b0, bus.fetch_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        cyc(1, 0, 0, 1);
        check("restart_if_pc", bus.if_pc, 32'h0);
        check("restart_count", {16'b0, bus.fetch_count}, 32'd1);

        // PC wrap at the top of the address space
        cyc(1, 1, 32'hFFFF_FFFE, 1);
        cyc(1, 0, 0, 1);
        check("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        check("wrap_pp4", bus.if_pc_plus4, 32'h0);
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Mixed handshake pattern
        rdy_pat = 16'b1011_0010_1110_0101;
        fe_pat  = 16'b1110_1111_0111_1011;
        for (int i = 0; i < 16; i++) cyc(fe_pat[i], (i == 9), 32'h80, rdy_pat[i]);
        repeat (4) cyc(1, 0, 0, 1);

        @(posedge clk);
        cmp_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
